// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 valid-mode convolution over a square Q8.8 image, one output per 10 cycles
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start_flag          start request, honoured only when idle
//   data                flattened IMG_W x IMG_W image, pixel (r,c) at index r*IMG_W+c
//   kernel, bias        3x3 weights (tap 3i+j) and bias, all signed Q8.8
//   out_pixel           saturated Q8.8 result for (out_row, out_col)
//   out_valid/out_ready result handshake
//   busy, done          run in progress / one-cycle end-of-run pulse
module conv3x3_stream #(
    parameter int IMG_W  = 30,
    parameter int DATA_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_flag,
    input  logic [IMG_W*IMG_W*DATA_W-1:0] data,
    input  logic [9*DATA_W-1:0]           kernel,
    input  logic [DATA_W-1:0]             bias,
    output logic [DATA_W-1:0]             out_pixel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4:0]                    out_row,
    output logic [4:0]                    out_col,
    output logic                          busy,
    output logic                          done
);
    localparam int NPIX  = IMG_W * IMG_W;
    localparam int IW    = $clog2(NPIX);
    localparam int OW    = IMG_W - 2;
    localparam int FRAC  = DATA_W / 2;
    localparam int ACC_W = 2 * DATA_W + 4;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_OUT, S_DONE} state_t;

    state_t                    r_state, w_state_nx;
    logic [DATA_W-1:0]         r_img [NPIX];
    logic [DATA_W-1:0]         r_kern [9];
    logic [DATA_W-1:0]         r_bias;
    logic signed [ACC_W-1:0]   r_acc;
    logic [3:0]                r_tap;
    logic [4:0]                r_row, r_col;
    logic [DATA_W-1:0]         r_pix;

    logic [1:0]                w_i, w_j;
    logic [IW-1:0]             w_idx;
    logic signed [DATA_W-1:0]  w_px, w_w;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_acc_nx, w_sh, w_bias_in, w_bias_reg;
    logic [DATA_W-1:0]         w_sat;
    logic                      w_ovf, w_col_wrap, w_last;

    // tap = 3i+j without a divider
    assign w_i   = (r_tap >= 4'd6) ? 2'd2 : (r_tap >= 4'd3) ? 2'd1 : 2'd0;
    assign w_j   = 2'(r_tap - ((r_tap >= 4'd6) ? 4'd6 : (r_tap >= 4'd3) ? 4'd3 : 4'd0));
    assign w_idx = (IW'(r_row) + IW'(w_i)) * IW'(IMG_W) + IW'(r_col) + IW'(w_j);
    assign w_px  = r_img[w_idx];
    assign w_w   = r_kern[r_tap];
    assign w_prod = w_px * w_w;
    assign w_acc_nx = r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

    // bias aligned to the Q16.16 product scale
    assign w_bias_in  = {{(ACC_W-DATA_W-FRAC){bias[DATA_W-1]}}, bias, {FRAC{1'b0}}};
    assign w_bias_reg = {{(ACC_W-DATA_W-FRAC){r_bias[DATA_W-1]}}, r_bias, {FRAC{1'b0}}};

    // result fits 16 bits only when everything from bit DATA_W-1 upward is a sign copy
    assign w_sh  = w_acc_nx >>> FRAC;
    assign w_ovf = !(&w_sh[ACC_W-1:DATA_W-1] || !(|w_sh[ACC_W-1:DATA_W-1]));
    assign w_sat = w_ovf ? (w_sh[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}})
                         : w_sh[DATA_W-1:0];

    assign w_col_wrap = r_col == 5'(OW - 1);
    assign w_last     = w_col_wrap && r_row == 5'(OW - 1);

    assign out_pixel = r_pix;
    assign out_row   = r_row;
    assign out_col   = r_col;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: w_state_nx = start_flag ? S_LOAD : S_IDLE;
            S_LOAD: begin
                busy       = 1'b1;
                w_state_nx = S_MAC;
            end
            S_MAC: begin
                busy       = 1'b1;
                w_state_nx = (r_tap == 4'd8) ? S_OUT : S_MAC;
            end
            S_OUT: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                w_state_nx = !out_ready ? S_OUT : w_last ? S_DONE : S_MAC;
            end
            S_DONE: begin
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // operand copies, held for the whole run so the input buses may change freely
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD) begin
            for (int n = 0; n < NPIX; n++)
                r_img[n] <= data[n*DATA_W +: DATA_W];
            for (int k = 0; k < 9; k++)
                r_kern[k] <= kernel[k*DATA_W +: DATA_W];
            r_bias <= bias;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_tap <= '0;
            r_row <= '0;
            r_col <= '0;
            r_pix <= '0;
        end else if (r_state == S_LOAD) begin
            r_acc <= w_bias_in;
            r_tap <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (r_state == S_MAC) begin
            r_acc <= w_acc_nx;
            r_tap <= (r_tap == 4'd8) ? 4'd0 : r_tap + 4'd1;
            if (r_tap == 4'd8)
                r_pix <= w_sat;
        end else if (r_state == S_OUT && out_ready && !w_last) begin
            r_acc <= w_bias_reg;
            r_tap <= '0;
            r_col <= w_col_wrap ? 5'd0 : r_col + 5'd1;
            r_row <= w_col_wrap ? r_row + 5'd1 : r_row;
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: scoreboard bench for conv3x3_stream covering function, timing, backpressure and reset
module tb_conv3x3_stream;
    localparam int W    = 30;
    localparam int N    = W * W;
    localparam int OW   = W - 2;
    localparam int NOUT = OW * OW;

    typedef struct packed {
        logic [15:0] px;
        logic [4:0]  r;
        logic [4:0]  c;
    } exp_t;

    logic            clk = 1'b0, rst = 1'b1, start_flag = 1'b0, out_ready = 1'b1;
    logic [N*16-1:0] data = '0;
    logic [143:0]    kernel = '0;
    logic [15:0]     bias = '0;
    logic [15:0]     out_pixel;
    logic            out_valid, busy, done;
    logic [4:0]      out_row, out_col;

    logic [15:0] img [N];
    logic [15:0] ker [9];
    exp_t        sb [$];
    exp_t        m_e;
    int          n_chk = 0, n_pass = 0, cyc = 0, e0 = 0;
    int          hs_count = 0, first_valid = -1, done_cyc = -1, done_count = 0, last_hs = -1;
    logic [15:0] first_px, last_px;

    conv3x3_stream dut (
        .clk(clk), .rst(rst), .start_flag(start_flag), .data(data), .kernel(kernel), .bias(bias),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input int r, input int c);
        longint acc = longint'($signed(bias)) * 256;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                acc += longint'($signed(img[(r+i)*W + c + j])) * longint'($signed(ker[3*i+j]));
        acc = acc >>> 8;
        return (acc > 32767) ? 16'h7fff : (acc < -32768) ? 16'h8000 : 16'(acc);
    endfunction

    // scoreboard: every accepted output is popped and compared; cycle stamps are relative to E0
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && first_valid < 0) first_valid = cyc - e0;
            if (done) begin
                done_count++;
                done_cyc = cyc - e0;
            end
            if (out_valid && out_ready) begin
                hs_count++;
                last_hs = cyc + 1 - e0;
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL out: unexpected output %h at (%0d,%0d), queue empty", out_pixel, out_row, out_col);
                end else begin
                    m_e = sb.pop_front();
                    if ({out_pixel, out_row, out_col} !== m_e)
                        $display("FAIL out: got %h (%0d,%0d) need %h (%0d,%0d)", out_pixel, out_row, out_col, m_e.px, m_e.r, m_e.c);
                    else
                        n_pass++;
                end
                if (hs_count == 1) first_px = out_pixel;
                last_px = out_pixel;
            end
        end
    end

    task automatic load_frame();
        for (int n = 0; n < N; n++) data[n*16 +: 16] = img[n];
        for (int k = 0; k < 9; k++) kernel[k*16 +: 16] = ker[k];
        for (int r = 0; r < OW; r++)
            for (int c = 0; c < OW; c++)
                sb.push_back({model(r, c), 5'(r), 5'(c)});
    endtask

    task automatic start_run();
        hs_count = 0; first_valid = -1; done_count = 0; done_cyc = -1; last_hs = -1;
        @(posedge clk); #1 start_flag = 1'b1;
        @(posedge clk); #1 e0 = cyc; start_flag = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int t = 0; t < lim && done_count == 0; t++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic set_identity();
        for (int n = 0; n < N; n++) img[n] = 16'(n);
        for (int k = 0; k < 9; k++) ker[k] = (k == 4) ? 16'h0100 : 16'h0000;
        bias = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({out_valid, done, busy, out_pixel, out_row, out_col} !== 29'd0)
            $display("FAIL reset: outputs %h, need 0", {out_valid, done, busy, out_pixel, out_row, out_col});
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy %b, need 0", busy);
        else n_pass++;
    endtask

    task automatic test_identity();
        set_identity();
        out_ready = 1'b1;
        load_frame();
        start_run();
        n_chk++;
        if (busy !== 1'b1) $display("FAIL busy_rise: busy %b after E0, need 1", busy);
        else n_pass++;
        wait_done(9000);
        n_chk++;
        if (hs_count !== NOUT || sb.size() != 0) $display("FAIL id_count: %0d outputs, %0d queued, need 784 and 0", hs_count, sb.size());
        else n_pass++;
        n_chk++;
        if (first_valid !== 10) $display("FAIL id_first_valid: first valid after E%0d, need E10", first_valid);
        else n_pass++;
        n_chk++;
        if (first_px !== 16'd31 || last_px !== 16'd868) $display("FAIL id_values: first %0d last %0d, need 31 and 868", first_px, last_px);
        else n_pass++;
        n_chk++;
        if (last_hs !== 7841 || done_cyc !== 7841 || done_count !== 1)
            $display("FAIL id_done: last hs E%0d done after E%0d x%0d, need E7841 E7841 x1", last_hs, done_cyc, done_count);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL id_idle: busy %b done %b, need 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_constant();
        for (int n = 0; n < N; n++) img[n] = 16'h0100;
        for (int k = 0; k < 9; k++) ker[k] = 16'h0100;
        bias = 16'h0080;
        load_frame();
        start_run();
        wait_done(9000);
        n_chk++;
        if (hs_count !== NOUT || sb.size() != 0 || last_px !== 16'h0980)
            $display("FAIL const: %0d outputs, last %h, need 784 outputs of 0980", hs_count, last_px);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [15:0] wv [2];
        logic [15:0] need [2];
        wv[0] = 16'h7fff; wv[1] = 16'h8000;
        need[0] = 16'h7fff; need[1] = 16'h8000;
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < N; n++) img[n] = 16'h7fff;
            for (int k = 0; k < 9; k++) ker[k] = wv[s];
            bias = 16'h0000;
            load_frame();
            start_run();
            wait_done(9000);
            n_chk++;
            if (hs_count !== NOUT || sb.size() != 0 || first_px !== need[s] || last_px !== need[s])
                $display("FAIL sat%0d: %0d outputs, first %h last %h, need 784 of %h", s, hs_count, first_px, last_px, need[s]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int hs_rel;
        int t;
        set_identity();
        out_ready = 1'b0;
        load_frame();
        start_run();
        for (t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            n_chk++;
            if ({out_valid, out_pixel, out_row, out_col} !== {1'b1, 16'd31, 5'd0, 5'd0})
                $display("FAIL bp_hold%0d: valid %b px %0d (%0d,%0d), need 1 31 (0,0)", k, out_valid, out_pixel, out_row, out_col);
            else n_pass++;
        end
        @(posedge clk); #1 out_ready = 1'b1;
        hs_rel = cyc + 1 - e0;
        @(posedge clk);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 30);
        n_chk++;
        if (cyc - e0 !== hs_rel + 9 || out_row !== 5'd0 || out_col !== 5'd1 || out_pixel !== 16'd32)
            $display("FAIL bp_next: valid after E%0d at (%0d,%0d) px %0d, need E%0d (0,1) 32", cyc - e0, out_row, out_col, out_pixel, hs_rel + 9);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset_mid();
        set_identity();
        out_ready = 1'b1;
        load_frame();
        start_run();
        for (int t = 0; t < 2000 && hs_count < 100; t++) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_chk++;
        if ({out_valid, done, busy, out_pixel, out_row, out_col} !== 29'd0 || hs_count !== 100)
            $display("FAIL rst_mid: outputs %h after %0d outputs, need 0 after 100", {out_valid, done, busy, out_pixel, out_row, out_col}, hs_count);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rst_mid_idle: busy %b, need 0", busy);
        else n_pass++;
        sb.delete();
        load_frame();
        start_run();
        wait_done(9000);
        n_chk++;
        if (hs_count !== NOUT || sb.size() != 0 || first_px !== 16'd31 || done_cyc !== 7841)
            $display("FAIL rst_rerun: %0d outputs first %0d done after E%0d, need 784 31 E7841", hs_count, first_px, done_cyc);
        else n_pass++;
    endtask

    task automatic test_spurious();
        for (int n = 0; n < N; n++) img[n] = 16'($urandom);
        for (int k = 0; k < 9; k++) ker[k] = 16'($urandom);
        bias = 16'($urandom);
        out_ready = 1'b1;
        load_frame();
        start_run();
        @(posedge clk); #1;
        for (int n = 0; n < N; n++) data[n*16 +: 16] = 16'($urandom);
        kernel = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
        bias = 16'($urandom);
        @(posedge clk); #1 start_flag = 1'b1;
        @(posedge clk); #1 start_flag = 1'b0;
        repeat (7) @(posedge clk);
        #1 start_flag = 1'b1;
        @(posedge clk); #1 start_flag = 1'b0;
        wait_done(9000);
        n_chk++;
        if (hs_count !== NOUT || sb.size() != 0) $display("FAIL spur_count: %0d outputs, %0d queued, need 784 and 0", hs_count, sb.size());
        else n_pass++;
        n_chk++;
        if (last_hs !== 7841 || done_cyc !== 7841 || done_count !== 1)
            $display("FAIL spur_done: last hs E%0d done after E%0d x%0d, need E7841 E7841 x1", last_hs, done_cyc, done_count);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL spur_idle: busy %b, need 0", busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_constant();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_spurious();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming 3x3 valid-mode convolution stage that sits directly downstream of the 900-pixel test-image ROM. On a start pulse it captures the flattened 30x30 image bus and a 3x3 kernel plus bias. It then computes the 28x28 output feature map one pixel at a time with a sequential signed Q8.8 MAC. Results go out over a valid/ready handshake to the next CNN layer (activation/pooling).

## Interface
- `IMG_W`, default 30: image width and height in pixels (square image).
- `DATA_W`, default 16: pixel/weight width, signed Q8.8.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start_flag`  in  1: start request; sampled only in IDLE.
- `data`  in  IMG_W*IMG_W*DATA_W (14400): flattened image; pixel (r,c) occupies bits [16*(r*30+c)+15 : 16*(r*30+c)].
- `kernel`  in  144: weight (i,j), with i,j in 0..2, at bits [16*(3i+j)+15 : 16*(3i+j)].
- `bias`  in  16: signed Q8.8 bias.
- `out_pixel`  out  16: signed Q8.8 result.
- `out_valid`  out  1: out_pixel/out_row/out_col valid.
- `out_ready`  in  1: consumer accepts when high together with out_valid.
- `out_row`, `out_col`  out  5 each: output coordinate, 0..27.
- `busy`  out  1: high in LOAD, MAC, OUT.
- `done`  out  1: one-cycle pulse after the last output is accepted.

## Operation
- FSM: IDLE, LOAD, MAC, OUT, DONE.
- IDLE: if start_flag is high, go to LOAD. The upstream ROM registers its output on the same edge that sees start_flag, so the image bus is valid one cycle later.
- LOAD: register `data`, `kernel`, and `bias` internally. Clear row, col, and tap to 0. Set acc = sign_extend(bias) <<< 8. Go to MAC.
- MAC: on each cycle, acc += pixel(row+i, col+j) * w(i,j), with tap = 3i+j stepping 0..8.
  - Products are full 32-bit signed.
  - acc is 36-bit signed; it cannot overflow for 9 taps plus bias.
  - After tap 8 is accumulated, go to OUT.
- OUT: out_valid = 1. out_pixel = sat16(acc >>> 8), using arithmetic shift; values above 32767 become 0x7FFF and values below -32768 become 0x8000.
  - While out_ready is low, out_pixel, out_row, and out_col hold stable.
  - On handshake at (27,27), go to DONE.
  - On any other handshake, advance col; when col wraps from 27 to 0, also advance row. Reload acc with the bias term, reset tap to 0, and go to MAC.
- DONE: done = 1 for one cycle, then go to IDLE.
- start_flag outside IDLE is ignored; it never restarts or corrupts an operation in progress.
- Internal image, kernel, and bias copies are stable for the whole run, so changes on `data`, `kernel`, or `bias` after LOAD have no effect.
- Reset (any state, including mid-run): state goes to IDLE; out_valid, done, busy, out_pixel, out_row, out_col, acc, and tap all go to 0. The image register is not reset.

## Timing
- Let edge E0 be the edge that samples start_flag high in IDLE.
- LOAD captures inputs at E1. MAC taps accumulate at E2..E10. out_valid is high from after E10.
- With out_ready held high:
  - handshake k occurs at E11+10k.
  - each output costs 10 cycles: 9 MAC cycles plus 1 OUT cycle.
  - the last handshake (k=783) is at E7841, done is high in the following cycle, and busy drops in that same cycle.
- The output register changes only on a handshake edge or when OUT is entered.
- busy rises the cycle after E0.

## Test plan
- **Identity kernel.** Raw pixel value = r*30+c, center weight = 0x0100, all other weights 0, bias 0.
  - Outputs are (r+1)*30+(c+1) in raster order: first 31 at (0,0), second 32, last 868 at (27,27).
  - Exactly 784 handshakes, first out_valid after E10, done pulse after E7841.
- **Constant image.** All pixels 0x0100, all weights 0x0100, bias 0x0080 -> every output is 0x0980 (9.5).
- **Saturation.** All pixels 0x7FFF and all weights 0x7FFF -> 0x7FFF. Same pixels with weights 0x8000 -> 0x8000.
- **Backpressure.** Hold out_ready low for 5 cycles when output (0,0) is presented.
  - out_valid, out_pixel, and coordinates stay stable for those 5 cycles.
  - No advance occurs; the next output (0,1) appears 10 cycles after the handshake.
- **Reset mid-run.** Assert rst for one cycle after 100 outputs.
  - The next cycle shows all outputs at 0 and state IDLE.
  - A new start yields the full 784-output sequence from (0,0).
- **Spurious start.** Pulse start_flag during MAC and during OUT -> the output sequence, count, and done timing are unchanged.
